// File: rtl/bp_tone_analyzer.sv
// Square-wave I/Q tone correlator for band-pass filter gain/phase characterization.
// Optional feature: define TONE_AN_PEAK_EN to add a peak |sample| output over the accumulation window.
module bp_tone_analyzer #(
    parameter int DW     = 12,
    parameter int ACCW   = 32,
    parameter int PHW    = 16,
    parameter int NW     = 16,
    parameter int SETTLE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [PHW-1:0]  fcw,
    input  logic [NW-1:0]   nsamp,
    input  logic            s_valid,
    input  logic [DW-1:0]   s_data,
    output logic            s_ready,
    output logic            busy,
    output logic            done,
    output logic [ACCW-1:0] i_acc,
    output logic [ACCW-1:0] q_acc,
`ifdef TONE_AN_PEAK_EN
    output logic [DW-1:0]   peak,
`endif
    output logic            ovf
);

    // state    | meaning
    // S_IDLE   | waiting for the first start after reset
    // S_SETTLE | discarding SETTLE samples while the filter transient dies out
    // S_ACC    | correlating nsamp samples, then one cycle to publish
    // S_DONE   | results held until the next start
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_ACC, S_DONE} state_t;

    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int CW = (SW > NW) ? SW : NW;
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

    state_t               state;
    logic [PHW-1:0]       phase;
    logic [PHW-1:0]       fcw_lat;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        n_lat;
    logic                 i_neg;
    logic                 q_neg;
    logic                 i_sat;
    logic                 q_sat;
    logic                 acc_step;
    logic                 idle_start;
    logic signed [ACCW:0] smp_ext;
    logic signed [ACCW:0] i_sum;
    logic signed [ACCW:0] q_sum;
    logic [ACCW-1:0]      i_next;
    logic [ACCW-1:0]      q_next;

    assign s_ready    = busy;
    assign idle_start = start && (state == S_IDLE || state == S_DONE);
    assign acc_step   = (state == S_ACC) && (cnt != n_lat) && s_valid;
    assign i_neg      = phase[PHW-1] ^ phase[PHW-2];
    assign q_neg      = phase[PHW-1];

    // One guard bit makes overflow visible as a mismatch of the top two sum bits.
    always_comb begin
        smp_ext = {{(ACCW + 1 - DW){s_data[DW-1]}}, s_data};
        i_sum   = {i_acc[ACCW-1], i_acc} + (i_neg ? -smp_ext : smp_ext);
        q_sum   = {q_acc[ACCW-1], q_acc} + (q_neg ? -smp_ext : smp_ext);
        i_sat   = i_sum[ACCW] != i_sum[ACCW-1];
        q_sat   = q_sum[ACCW] != q_sum[ACCW-1];
        i_next  = i_sat ? {i_sum[ACCW], {(ACCW-1){~i_sum[ACCW]}}} : i_sum[ACCW-1:0];
        q_next  = q_sat ? {q_sum[ACCW], {(ACCW-1){~q_sum[ACCW]}}} : q_sum[ACCW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            phase   <= '0;
            fcw_lat <= '0;
            cnt     <= '0;
            n_lat   <= '0;
            i_acc   <= '0;
            q_acc   <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        fcw_lat <= fcw;
                        n_lat   <= CW'(nsamp);
                        phase   <= '0;
                        cnt     <= '0;
                        i_acc   <= '0;
                        q_acc   <= '0;
                        ovf     <= 1'b0;
                        busy    <= 1'b1;
                        state   <= (SETTLE == 0) ? S_ACC : S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (s_valid) begin
                        phase <= phase + fcw_lat;
                        if (cnt == SETTLE_LAST) begin
                            cnt   <= '0;
                            state <= S_ACC;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_ACC: begin
                    // The cycle after the last sample publishes; a sample offered then is dropped.
                    if (cnt == n_lat) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (s_valid) begin
                        phase <= phase + fcw_lat;
                        cnt   <= cnt + CW'(1);
                        i_acc <= i_next;
                        q_acc <= q_next;
                        ovf   <= ovf | i_sat | q_sat;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef TONE_AN_PEAK_EN
    logic [DW-1:0] mag;

    always_comb begin
        mag = s_data[DW-1] ? (-s_data) : s_data;
        if (mag[DW-1]) mag = {1'b0, {(DW-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            peak <= '0;
        end else if (idle_start) begin
            peak <= '0;
        end else if (acc_step && (mag > peak)) begin
            peak <= mag;
        end
    end
`endif

endmodule

// File: tb/tb_bp_tone_analyzer.sv
// Bench for bp_tone_analyzer: cycle-level behavioural model plus directed literal checks.
module tb_bp_tone_analyzer;

    localparam int DW   = 12;
    localparam int ACCW = 16;
    localparam int PHW  = 16;
    localparam int NW   = 16;
    localparam int ST   = 4;
    localparam longint AMAX = (longint'(1) <<< (ACCW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) <<< (ACCW - 1));

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [PHW-1:0]  fcw;
    logic [NW-1:0]   nsamp;
    logic            s_valid;
    logic [DW-1:0]   s_data;
    logic            s_ready;
    logic            busy;
    logic            done;
    logic [ACCW-1:0] i_acc;
    logic [ACCW-1:0] q_acc;
    logic            ovf;
`ifdef TONE_AN_PEAK_EN
    logic [DW-1:0]   peak;
`endif

    int total = 0;
    int bad   = 0;
    int hs    = 0;
    bit chk_en = 1'b0;
    int smp [0:255];

    bit     m_busy = 1'b0;
    bit     m_done = 1'b0;
    bit     m_ovf  = 1'b0;
    longint m_i    = 0;
    longint m_q    = 0;
    longint m_peak = 0;
    longint fcw_m  = 0;
    int     n_m    = 0;
    int     k      = 0;

    always #5 clk = ~clk;

    bp_tone_analyzer #(.DW(DW), .ACCW(ACCW), .PHW(PHW), .NW(NW), .SETTLE(ST)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .fcw(fcw),
        .nsamp(nsamp),
        .s_valid(s_valid),
        .s_data(s_data),
        .s_ready(s_ready),
        .busy(busy),
        .done(done),
        .i_acc(i_acc),
        .q_acc(q_acc),
`ifdef TONE_AN_PEAK_EN
        .peak(peak),
`endif
        .ovf(ovf)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: sample number k of a measurement sees reference phase k*fcw; quadrants 1,2 invert I, 2,3 invert Q.
    initial forever begin
        longint ph;
        longint v;
        longint si;
        longint sq;
        longint mg;
        @(posedge clk);
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
            m_i = 0; m_q = 0; m_peak = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1; fcw_m = longint'(fcw); n_m = int'(nsamp); k = 0;
                    m_i = 0; m_q = 0; m_ovf = 1'b0; m_peak = 0;
                end
            end else if (k == ST + n_m) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else if (s_valid) begin
                if (k >= ST) begin
                    ph = (longint'(k) * fcw_m) % 65536;
                    v  = longint'($signed(s_data));
                    si = (ph / 16384 == 1 || ph / 16384 == 2) ? -1 : 1;
                    sq = (ph >= 32768) ? -1 : 1;
                    m_i = m_i + si * v;
                    m_q = m_q + sq * v;
                    if (m_i > AMAX) begin m_i = AMAX; m_ovf = 1'b1; end
                    if (m_i < AMIN) begin m_i = AMIN; m_ovf = 1'b1; end
                    if (m_q > AMAX) begin m_q = AMAX; m_ovf = 1'b1; end
                    if (m_q < AMIN) begin m_q = AMIN; m_ovf = 1'b1; end
                    mg = (v < 0) ? -v : v;
                    if (mg > 2047) mg = 2047;
                    if (mg > m_peak) m_peak = mg;
                end
                k++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy", busy, longint'(m_busy));
            chk("s_ready", s_ready, longint'(m_busy));
            chk("done", done, longint'(m_done));
            chk("i_acc", longint'($signed(i_acc)), m_i);
            chk("q_acc", longint'($signed(q_acc)), m_q);
            chk("ovf", ovf, longint'(m_ovf));
`ifdef TONE_AN_PEAK_EN
            chk("peak", peak, m_peak);
`endif
        end
    end

    task automatic begin_meas(input logic [PHW-1:0] f, input logic [NW-1:0] n);
        @(negedge clk);
        start = 1'b1; fcw = f; nsamp = n; s_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    // vmode: 0 gap-free, 1 valid every other cycle, 2 random valid
    task automatic send(input int cnt, input int vmode, input int poke_at);
        int i = 0;
        int cyc = 0;
        while (i < cnt && cyc < 2000) begin
            s_data  = smp[i][DW-1:0];
            s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
            start   = (cyc == poke_at);
            if (cyc == poke_at) begin
                fcw   = ~fcw;
                nsamp = 3;
            end
            if (s_valid && s_ready) begin
                i++;
                hs++;
            end
            cyc++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        start   = 1'b0;
        if (i < cnt) chk("send_timeout", i, cnt);
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk({nm, "_done_latency"}, t, 1);
    endtask

    task automatic run(input logic [PHW-1:0] f, input int n, input int vmode, input int poke_at, input string nm);
        hs = 0;
        begin_meas(f, NW'(n));
        send(ST + n, vmode, poke_at);
        wait_done(nm);
        chk({nm, "_accepted"}, hs, ST + n);
    endtask

    initial begin
        longint g_i;
        longint g_q;
        longint g_o;
        int dcount;
        rst = 1'b1; start = 1'b0; fcw = '0; nsamp = '0; s_valid = 1'b0; s_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_i", i_acc, 0);
        chk("rst_q", q_acc, 0);
        chk("rst_ovf", ovf, 0);

        for (int i = 0; i < 256; i++) smp[i] = 100;
        run(16'h4000, 16, 0, -1, "dc");
        chk("dc_i", longint'($signed(i_acc)), 0);
        chk("dc_q", longint'($signed(q_acc)), 0);
        chk("dc_ovf", ovf, 0);

        for (int i = 0; i < 256; i++) smp[i] = ((i % 4) < 2) ? 100 : -100;
        run(16'h4000, 16, 0, -1, "inphase");
        chk("inphase_i", longint'($signed(i_acc)), 0);
        chk("inphase_q", longint'($signed(q_acc)), 1600);

        for (int i = 0; i < 256; i++) smp[i] = (((i + 1) % 4) < 2) ? 100 : -100;
        run(16'h4000, 16, 0, -1, "quad");
        chk("quad_i", longint'($signed(i_acc)), 1600);
        chk("quad_q", longint'($signed(q_acc)), 0);

        for (int i = 0; i < 256; i++) smp[i] = 2047;
        run(16'h0000, 100, 0, -1, "sat");
        chk("sat_q", longint'($signed(q_acc)), 32767);
        chk("sat_i", longint'($signed(i_acc)), 32767);
        chk("sat_ovf", ovf, 1);

        for (int i = 0; i < 12; i++) smp[i] = int'($urandom_range(0, 4095)) - 2048;
        run(16'h1234, 8, 0, -1, "gapfree");
        g_i = m_i; g_q = m_q; g_o = longint'(m_ovf);
        run(16'h1234, 8, 1, 13, "toggle");
        chk("toggle_i_vs_gapfree", longint'($signed(i_acc)), g_i);
        chk("toggle_q_vs_gapfree", longint'($signed(q_acc)), g_q);
        chk("toggle_ovf_vs_gapfree", ovf, g_o);

        hs = 0;
        begin_meas(16'h2000, 20);
        send(10, 0, -1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_i", i_acc, 0);
        chk("midrst_q", q_acc, 0);
        chk("midrst_ovf", ovf, 0);
        dcount = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("midrst_no_done", dcount, 0);

        for (int i = 0; i < 256; i++) smp[i] = 777;
        run(16'h1000, 0, 0, -1, "nsamp0");
        chk("nsamp0_i", i_acc, 0);
        chk("nsamp0_q", q_acc, 0);

`ifdef TONE_AN_PEAK_EN
        for (int i = 0; i < 12; i++) smp[i] = 5 * i - 20;
        smp[6] = -2048;
        run(16'h0800, 8, 0, -1, "peak");
        chk("peak_clamp", peak, 2047);
`endif

        for (int r = 0; r < 25; r++) begin
            int n;
            n = int'($urandom_range(0, 30));
            for (int i = 0; i < ST + n; i++) begin
                case ($urandom_range(0, 7))
                    0:       smp[i] = -2048;
                    1:       smp[i] = 2047;
                    default: smp[i] = int'($urandom_range(0, 4095)) - 2048;
                endcase
            end
            run(PHW'($urandom), n, int'($urandom_range(0, 2)), -1, "rand");
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

endmodule
